// File: rtl/id_stage_pipe_pkg.sv
// Shared MIPS32 decode definitions: instruction field positions, opcode/funct
// encodings, ALU operation and instruction-type codes.
package id_stage_pipe_pkg;

   localparam int unsigned OPC_W   = 6;
   localparam int unsigned FIELD_W = 5;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RS_LSB  = 21;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_LSB  = 11;
   localparam int unsigned SA_LSB  = 6;
   localparam int unsigned FN_LSB  = 0;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;
   localparam logic [5:0] OP_LUI     = 6'h0f;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_MOVZ = 6'h0a;
   localparam logic [5:0] FN_MOVN = 6'h0b;
   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MTHI = 6'h11;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MTLO = 6'h13;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;

   localparam logic [3:0] NOP_ALUOP  = 4'h0;
   localparam logic [3:0] ALUOP_AND  = 4'h1;
   localparam logic [3:0] ALUOP_OR   = 4'h2;
   localparam logic [3:0] ALUOP_XOR  = 4'h3;
   localparam logic [3:0] ALUOP_NOR  = 4'h4;
   localparam logic [3:0] ALUOP_LUI  = 4'h5;
   localparam logic [3:0] ALUOP_SLL  = 4'h6;
   localparam logic [3:0] ALUOP_SRL  = 4'h7;
   localparam logic [3:0] ALUOP_SRA  = 4'h8;
   localparam logic [3:0] ALUOP_MOVN = 4'h9;
   localparam logic [3:0] ALUOP_MOVZ = 4'ha;
   localparam logic [3:0] ALUOP_MFHI = 4'hb;
   localparam logic [3:0] ALUOP_MFLO = 4'hc;
   localparam logic [3:0] ALUOP_MTHI = 4'hd;
   localparam logic [3:0] ALUOP_MTLO = 4'he;

   localparam logic [1:0] TYPE_R     = 2'd0;
   localparam logic [1:0] TYPE_I     = 2'd1;
   localparam logic [1:0] TYPE_SHIFT = 2'd2;
   localparam logic [1:0] TYPE_HILO  = 2'd3;

   // Decoded control word; unused source fields stay 0 so they never forward or stall.
   typedef struct packed {
      logic [3:0]         aluop;
      logic [1:0]         itype;
      logic [FIELD_W-1:0] src1;
      logic [FIELD_W-1:0] src2;
      logic [FIELD_W-1:0] waddr;
      logic               use_imm;
      logic               reg_wr;
      logic               to_hi;
      logic               to_lo;
      logic               is_movn;
      logic               is_movz;
   } dec_t;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding mux: register 0 reads as zero, then EX beats MEM beats
// the register file.
module id_fwd_mux #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic [RADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0]  rf_rdata,
   input  logic               ex_wr,
   input  logic [RADDR_W-1:0] ex_waddr,
   input  logic [DATA_W-1:0]  ex_wdata,
   input  logic               mem_wr,
   input  logic [RADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0]  mem_wdata,
   output logic [DATA_W-1:0]  data_c
);

   always_comb begin
      data_c = rf_rdata;
      if (raddr == '0)
         data_c = '0;
      else if (ex_wr && (ex_waddr == raddr))
         data_c = ex_wdata;
      else if (mem_wr && (mem_waddr == raddr))
         data_c = mem_wdata;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS32 instruction-decode stage: decode, operand forwarding, load-use
// interlock and the ID/EX pipeline register with valid/ready handshake.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   input  logic [31:0]        if_instr,
   input  logic [DATA_W-1:0]  if_pc,
   output logic               id_ready,
   input  logic               flush,
   output logic [RADDR_W-1:0] rf_raddr1,
   output logic [RADDR_W-1:0] rf_raddr2,
   input  logic [DATA_W-1:0]  rf_rdata1,
   input  logic [DATA_W-1:0]  rf_rdata2,
   input  logic               ex_fwd_wr,
   input  logic               ex_fwd_load,
   input  logic [RADDR_W-1:0] ex_fwd_waddr,
   input  logic [DATA_W-1:0]  ex_fwd_wdata,
   input  logic               mem_fwd_wr,
   input  logic [RADDR_W-1:0] mem_fwd_waddr,
   input  logic [DATA_W-1:0]  mem_fwd_wdata,
   input  logic               ex_ready,
   output logic               ex_valid,
   output logic [3:0]         ex_aluop,
   output logic [1:0]         ex_instr_type,
   output logic [DATA_W-1:0]  ex_op1,
   output logic [DATA_W-1:0]  ex_op2,
   output logic [RADDR_W-1:0] ex_waddr,
   output logic               ex_reg_wr,
   output logic               ex_mem_wr,
   output logic               ex_to_hi,
   output logic               ex_to_lo,
   output logic [DATA_W-1:0]  ex_pc,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic [OPC_W-1:0]   opcode;
   logic [OPC_W-1:0]   funct;
   logic [FIELD_W-1:0] rs;
   logic [FIELD_W-1:0] rt;
   logic [FIELD_W-1:0] rd;
   logic [FIELD_W-1:0] sa;
   logic [IMM_W-1:0]   imm;
   dec_t               dec;
   logic [DATA_W-1:0]  ext_imm;
   logic [DATA_W-1:0]  fwd1;
   logic [DATA_W-1:0]  fwd2;
   logic               cond_ok;
   logic               hazard;
   logic               advance;
   logic               load;

   assign opcode = if_instr[OPC_LSB +: OPC_W];
   assign rs     = if_instr[RS_LSB +: FIELD_W];
   assign rt     = if_instr[RT_LSB +: FIELD_W];
   assign rd     = if_instr[RD_LSB +: FIELD_W];
   assign sa     = if_instr[SA_LSB +: FIELD_W];
   assign funct  = if_instr[FN_LSB +: OPC_W];
   assign imm    = if_instr[0 +: IMM_W];

   // Opcode/funct decode; anything outside the supported set stays a NOP.
   always_comb begin
      dec       = '0;
      dec.aluop = NOP_ALUOP;
      dec.itype = TYPE_R;
      ext_imm   = '0;
      case (opcode)
         OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
            dec.itype   = TYPE_I;
            dec.use_imm = 1'b1;
            dec.reg_wr  = 1'b1;
            dec.waddr   = rt;
            dec.src1    = rs;
            ext_imm     = DATA_W'(imm);
            case (opcode)
               OP_ORI:  dec.aluop = ALUOP_OR;
               OP_ANDI: dec.aluop = ALUOP_AND;
               OP_XORI: dec.aluop = ALUOP_XOR;
               default: begin
                  dec.aluop = ALUOP_LUI;
                  dec.src1  = '0;
                  ext_imm   = DATA_W'({imm, 16'h0000});
               end
            endcase
         end
         OP_SPECIAL: begin
            case (funct)
               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_MOVN, FN_MOVZ: begin
                  dec.src1   = rs;
                  dec.src2   = rt;
                  dec.waddr  = rd;
                  dec.reg_wr = 1'b1;
               end
               // Shift-by-sa carries rt on port 1 and sa as the immediate.
               FN_SLL, FN_SRL, FN_SRA: begin
                  dec.itype   = TYPE_SHIFT;
                  dec.src1    = rt;
                  dec.use_imm = 1'b1;
                  dec.waddr   = rd;
                  dec.reg_wr  = 1'b1;
                  ext_imm     = DATA_W'(sa);
               end
               FN_SLLV, FN_SRLV, FN_SRAV: begin
                  dec.itype  = TYPE_SHIFT;
                  dec.src1   = rt;
                  dec.src2   = rs;
                  dec.waddr  = rd;
                  dec.reg_wr = 1'b1;
               end
               FN_MFHI, FN_MFLO: begin
                  dec.itype  = TYPE_HILO;
                  dec.waddr  = rd;
                  dec.reg_wr = 1'b1;
               end
               FN_MTHI, FN_MTLO: begin
                  dec.itype = TYPE_HILO;
                  dec.src1  = rs;
                  dec.to_hi = (funct == FN_MTHI);
                  dec.to_lo = (funct == FN_MTLO);
               end
               default: ;
            endcase
            case (funct)
               FN_AND:          dec.aluop = ALUOP_AND;
               FN_OR:           dec.aluop = ALUOP_OR;
               FN_XOR:          dec.aluop = ALUOP_XOR;
               FN_NOR:          dec.aluop = ALUOP_NOR;
               FN_SLL, FN_SLLV: dec.aluop = ALUOP_SLL;
               FN_SRL, FN_SRLV: dec.aluop = ALUOP_SRL;
               FN_SRA, FN_SRAV: dec.aluop = ALUOP_SRA;
               FN_MOVN:         dec.aluop = ALUOP_MOVN;
               FN_MOVZ:         dec.aluop = ALUOP_MOVZ;
               FN_MFHI:         dec.aluop = ALUOP_MFHI;
               FN_MFLO:         dec.aluop = ALUOP_MFLO;
               FN_MTHI:         dec.aluop = ALUOP_MTHI;
               FN_MTLO:         dec.aluop = ALUOP_MTLO;
               default:         dec.aluop = NOP_ALUOP;
            endcase
            dec.is_movn = (funct == FN_MOVN);
            dec.is_movz = (funct == FN_MOVZ);
         end
         default: ;
      endcase
   end

   assign rf_raddr1 = RADDR_W'(dec.src1);
   assign rf_raddr2 = RADDR_W'(dec.src2);

   id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd1 (
      .raddr(rf_raddr1), .rf_rdata(rf_rdata1),
      .ex_wr(ex_fwd_wr), .ex_waddr(ex_fwd_waddr), .ex_wdata(ex_fwd_wdata),
      .mem_wr(mem_fwd_wr), .mem_waddr(mem_fwd_waddr), .mem_wdata(mem_fwd_wdata),
      .data_c(fwd1)
   );

   id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd2 (
      .raddr(rf_raddr2), .rf_rdata(rf_rdata2),
      .ex_wr(ex_fwd_wr), .ex_waddr(ex_fwd_waddr), .ex_wdata(ex_fwd_wdata),
      .mem_wr(mem_fwd_wr), .mem_waddr(mem_fwd_waddr), .mem_wdata(mem_fwd_wdata),
      .data_c(fwd2)
   );

   // MOVN/MOVZ test the forwarded rt value (port 2).
   always_comb begin
      cond_ok = 1'b1;
      if (dec.is_movn)
         cond_ok = (fwd2 != '0);
      else if (dec.is_movz)
         cond_ok = (fwd2 == '0);
   end

   // An invalid ID slot has no used sources, so it can never interlock.
   assign hazard   = if_valid & ex_fwd_load & ex_fwd_wr & (ex_fwd_waddr != '0) &
                     ((ex_fwd_waddr == rf_raddr1) | (ex_fwd_waddr == rf_raddr2));
   assign advance  = ex_ready | ~ex_valid;
   assign id_ready = ~hazard & advance;
   assign load     = if_valid & id_ready;

   // ID/EX register: flush beats load; bubbles clear the write enables.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_aluop      <= ALUOP_OR;
         ex_instr_type <= TYPE_I;
         ex_op1        <= '0;
         ex_op2        <= '0;
         ex_waddr      <= '0;
         ex_reg_wr     <= 1'b0;
         ex_mem_wr     <= 1'b0;
         ex_to_hi      <= 1'b0;
         ex_to_lo      <= 1'b0;
         ex_pc         <= '0;
         stall_cnt     <= '0;
      end else begin
         if (flush || (advance && !load)) begin
            ex_valid  <= 1'b0;
            ex_reg_wr <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_to_hi  <= 1'b0;
            ex_to_lo  <= 1'b0;
         end else if (load) begin
            ex_valid      <= 1'b1;
            ex_aluop      <= dec.aluop;
            ex_instr_type <= dec.itype;
            ex_op1        <= fwd1;
            ex_op2        <= dec.use_imm ? ext_imm : fwd2;
            ex_waddr      <= cond_ok ? RADDR_W'(dec.waddr) : '0;
            ex_reg_wr     <= dec.reg_wr & cond_ok;
            ex_mem_wr     <= 1'b0;
            ex_to_hi      <= dec.to_hi;
            ex_to_lo      <= dec.to_lo;
            ex_pc         <= if_pc;
         end
         if (hazard && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: expected ID/EX contents are queued on
// acceptance and compared whenever EX takes a valid entry.
module tb_id_stage_pipe;
   import id_stage_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        flush;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        ex_fwd_wr, ex_fwd_load;
   logic [4:0]  ex_fwd_waddr;
   logic [31:0] ex_fwd_wdata;
   logic        mem_fwd_wr;
   logic [4:0]  mem_fwd_waddr;
   logic [31:0] mem_fwd_wdata;
   logic        ex_ready;
   logic        ex_valid;
   logic [3:0]  ex_aluop;
   logic [1:0]  ex_instr_type;
   logic [31:0] ex_op1, ex_op2;
   logic [4:0]  ex_waddr;
   logic        ex_reg_wr, ex_mem_wr, ex_to_hi, ex_to_lo;
   logic [31:0] ex_pc;
   logic [15:0] stall_cnt;

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_fwd_wr(ex_fwd_wr),
      .ex_fwd_load(ex_fwd_load), .ex_fwd_waddr(ex_fwd_waddr), .ex_fwd_wdata(ex_fwd_wdata),
      .mem_fwd_wr(mem_fwd_wr), .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
      .ex_instr_type(ex_instr_type), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_waddr(ex_waddr),
      .ex_reg_wr(ex_reg_wr), .ex_mem_wr(ex_mem_wr), .ex_to_hi(ex_to_hi), .ex_to_lo(ex_to_lo),
      .ex_pc(ex_pc), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  aluop;
      logic [1:0]  itype;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  waddr;
      logic        reg_wr;
      logic        to_hi;
      logic        to_lo;
      logic [31:0] pc;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_stall = 0;
   logic [31:0] rf [32];

   // Register file model; register 0 holds garbage to prove the zero rule.
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sa, logic [5:0] fn);
      return {OP_SPECIAL, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] rv(logic [4:0] r);
      return (r == 5'd0) ? 32'h0 : rf[r];
   endfunction

   function automatic exp_t mk(logic [3:0] aluop, logic [1:0] itype, logic [31:0] op1,
                               logic [31:0] op2, logic [4:0] waddr, logic reg_wr,
                               logic to_hi, logic to_lo, logic [31:0] pc);
      exp_t e;
      e.aluop = aluop; e.itype = itype; e.op1 = op1; e.op2 = op2; e.waddr = waddr;
      e.reg_wr = reg_wr; e.to_hi = to_hi; e.to_lo = to_lo; e.pc = pc;
      return e;
   endfunction

   // Scoreboard: one entry leaves ID/EX on every valid & ready cycle.
   always @(negedge clk) begin
      exp_t e;
      exp_t got;
      if (!rst && ex_valid && ex_ready) begin
         checks++;
         got = mk(ex_aluop, ex_instr_type, ex_op1, ex_op2, ex_waddr, ex_reg_wr,
                  ex_to_hi, ex_to_lo, ex_pc);
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got pc=%h aluop=%h with empty queue", ex_pc, ex_aluop);
         end else begin
            e = sbq.pop_front();
            if (got !== e || ex_mem_wr !== 1'b0) begin
               errors++;
               $display("FAIL sb_pc_%h: got aluop=%h type=%h op1=%h op2=%h waddr=%0d wr=%b hi=%b lo=%b mw=%b, want aluop=%h type=%h op1=%h op2=%h waddr=%0d wr=%b hi=%b lo=%b mw=0",
                        e.pc, ex_aluop, ex_instr_type, ex_op1, ex_op2, ex_waddr, ex_reg_wr,
                        ex_to_hi, ex_to_lo, ex_mem_wr, e.aluop, e.itype, e.op1, e.op2,
                        e.waddr, e.reg_wr, e.to_hi, e.to_lo);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
      ex_fwd_wr = 1'b0; ex_fwd_load = 1'b0; ex_fwd_waddr = '0; ex_fwd_wdata = '0;
      mem_fwd_wr = 1'b0; mem_fwd_waddr = '0; mem_fwd_wdata = '0;
   endtask

   task automatic issue(logic [31:0] instr, logic [31:0] pc, exp_t e);
      if_valid = 1'b1; if_instr = instr; if_pc = pc;
      sbq.push_back(e);
      tick();
      if_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      if_instr = '0; if_pc = '0;
      tick(); tick();
      checks++;
      if (ex_valid !== 1'b0 || ex_aluop !== ALUOP_OR || ex_instr_type !== TYPE_I) begin
         errors++;
         $display("FAIL reset_ctrl: got valid=%b aluop=%h type=%h, want 0/%h/%h",
                  ex_valid, ex_aluop, ex_instr_type, ALUOP_OR, TYPE_I);
      end
      checks++;
      if ({ex_op1, ex_op2, ex_pc, ex_waddr, ex_reg_wr, ex_mem_wr, ex_to_hi, ex_to_lo} !== '0 ||
          stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: got op1=%h op2=%h pc=%h waddr=%0d wr=%b stall=%0d, want all 0",
                  ex_op1, ex_op2, ex_pc, ex_waddr, ex_reg_wr, stall_cnt);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_id_ready: got %b, want 1", id_ready);
      end
   endtask

   task automatic test_ori();
      rf[1] = 32'h1234_0000;
      issue(enc_i(OP_ORI, 5'd1, 5'd2, 16'hFFFF), 32'h100,
            mk(ALUOP_OR, TYPE_I, 32'h1234_0000, 32'h0000_FFFF, 5'd2, 1'b1, 1'b0, 1'b0, 32'h100));
      checks++;
      if (ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL ori_latency: ex_valid got %b, want 1", ex_valid);
      end
      tick();
   endtask

   task automatic test_forwarding();
      ex_fwd_wr = 1'b1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'hA;
      mem_fwd_wr = 1'b1; mem_fwd_waddr = 5'd2; mem_fwd_wdata = 32'hC;
      issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, FN_OR), 32'h110,
            mk(ALUOP_OR, TYPE_R, 32'hA, 32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 32'h110));
      mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'hB;
      issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, FN_OR), 32'h114,
            mk(ALUOP_OR, TYPE_R, 32'hA, rf[2], 5'd3, 1'b1, 1'b0, 1'b0, 32'h114));
      ex_fwd_wr = 1'b0;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL fwd_throughput: id_ready got %b, want 1", id_ready);
      end
      issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, FN_OR), 32'h118,
            mk(ALUOP_OR, TYPE_R, 32'hB, rf[2], 5'd3, 1'b1, 1'b0, 1'b0, 32'h118));
      ex_fwd_wr = 1'b1; ex_fwd_waddr = 5'd0; ex_fwd_wdata = 32'h77;
      mem_fwd_waddr = 5'd0; mem_fwd_wdata = 32'h88;
      issue(enc_r(5'd0, 5'd2, 5'd3, 5'd0, FN_XOR), 32'h11c,
            mk(ALUOP_XOR, TYPE_R, 32'h0, rf[2], 5'd3, 1'b1, 1'b0, 1'b0, 32'h11c));
      idle();
      tick();
   endtask

   task automatic test_load_use();
      ex_fwd_wr = 1'b1; ex_fwd_load = 1'b1; ex_fwd_waddr = 5'd4; ex_fwd_wdata = 32'h999;
      if_valid = 1'b1; if_instr = enc_r(5'd4, 5'd0, 5'd5, 5'd0, FN_AND); if_pc = 32'h200;
      #1;
      checks++;
      if (id_ready !== 1'b0) begin
         errors++;
         $display("FAIL lu_id_ready: got %b, want 0", id_ready);
      end
      tick();
      exp_stall++;
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL lu_bubble: got valid=%b stall=%0d, want 0/%0d", ex_valid, stall_cnt, exp_stall);
      end
      ex_fwd_wr = 1'b0; ex_fwd_load = 1'b0;
      mem_fwd_wr = 1'b1; mem_fwd_waddr = 5'd4; mem_fwd_wdata = 32'h55;
      #1;
      checks++;
      if (id_ready !== 1'b1) begin
         errors++;
         $display("FAIL lu_release: id_ready got %b, want 1", id_ready);
      end
      sbq.push_back(mk(ALUOP_AND, TYPE_R, 32'h55, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h200));
      tick();
      if_valid = 1'b0;
      checks++;
      if (ex_valid !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL lu_issue: got valid=%b stall=%0d, want 1/%0d", ex_valid, stall_cnt, exp_stall);
      end
      idle();
      tick();
      // Flush in a hazard cycle: no stall count, bubble regardless.
      ex_fwd_wr = 1'b1; ex_fwd_load = 1'b1; ex_fwd_waddr = 5'd4;
      if_valid = 1'b1; flush = 1'b1;
      tick();
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL lu_flush: got valid=%b stall=%0d, want 0/%0d", ex_valid, stall_cnt, exp_stall);
      end
      idle();
      tick();
   endtask

   task automatic test_movnz();
      ex_fwd_wr = 1'b1; ex_fwd_waddr = 5'd8; ex_fwd_wdata = 32'h0;
      issue(enc_r(5'd7, 5'd8, 5'd6, 5'd0, FN_MOVZ), 32'h300,
            mk(ALUOP_MOVZ, TYPE_R, rf[7], 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h300));
      ex_fwd_wdata = 32'h5;
      issue(enc_r(5'd7, 5'd8, 5'd6, 5'd0, FN_MOVZ), 32'h304,
            mk(ALUOP_MOVZ, TYPE_R, rf[7], 32'h5, 5'd0, 1'b0, 1'b0, 1'b0, 32'h304));
      issue(enc_r(5'd7, 5'd8, 5'd6, 5'd0, FN_MOVN), 32'h308,
            mk(ALUOP_MOVN, TYPE_R, rf[7], 32'h5, 5'd6, 1'b1, 1'b0, 1'b0, 32'h308));
      ex_fwd_wdata = 32'h0;
      issue(enc_r(5'd7, 5'd8, 5'd6, 5'd0, FN_MOVN), 32'h30c,
            mk(ALUOP_MOVN, TYPE_R, rf[7], 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h30c));
      idle();
      tick();
   endtask

   task automatic test_shift_hilo();
      issue(enc_r(5'd0, 5'd11, 5'd10, 5'd5, FN_SLL), 32'h500,
            mk(ALUOP_SLL, TYPE_SHIFT, rf[11], 32'd5, 5'd10, 1'b1, 1'b0, 1'b0, 32'h500));
      issue(enc_r(5'd14, 5'd13, 5'd12, 5'd0, FN_SRAV), 32'h504,
            mk(ALUOP_SRA, TYPE_SHIFT, rf[13], rf[14], 5'd12, 1'b1, 1'b0, 1'b0, 32'h504));
      issue(enc_i(OP_LUI, 5'd0, 5'd15, 16'hABCD), 32'h508,
            mk(ALUOP_LUI, TYPE_I, 32'h0, 32'hABCD_0000, 5'd15, 1'b1, 1'b0, 1'b0, 32'h508));
      issue(enc_r(5'd16, 5'd0, 5'd0, 5'd0, FN_MTHI), 32'h50c,
            mk(ALUOP_MTHI, TYPE_HILO, rf[16], 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h50c));
      issue(enc_r(5'd0, 5'd0, 5'd17, 5'd0, FN_MFLO), 32'h510,
            mk(ALUOP_MFLO, TYPE_HILO, 32'h0, 32'h0, 5'd17, 1'b1, 1'b0, 1'b0, 32'h510));
      issue(enc_i(6'h23, 5'd1, 5'd2, 16'h0004), 32'h514,
            mk(NOP_ALUOP, TYPE_R, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h514));
      issue(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3f), 32'h518,
            mk(NOP_ALUOP, TYPE_R, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h518));
      tick();
   endtask

   task automatic test_hold_flush();
      issue(enc_i(OP_XORI, 5'd1, 5'd9, 16'h00F0), 32'h400,
            mk(ALUOP_XOR, TYPE_I, rf[1], 32'h00F0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h400));
      ex_ready = 1'b0;
      if_valid = 1'b1; if_instr = enc_i(OP_ORI, 5'd1, 5'd2, 16'h1111); if_pc = 32'h404;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (id_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_id_ready_%0d: got %b, want 0", i, id_ready);
         end
         tick();
         checks++;
         if (ex_valid !== 1'b1 || ex_op1 !== rf[1] || ex_op2 !== 32'h00F0 ||
             ex_waddr !== 5'd9 || ex_pc !== 32'h400 || ex_aluop !== ALUOP_XOR) begin
            errors++;
            $display("FAIL hold_%0d: got valid=%b op1=%h op2=%h waddr=%0d pc=%h, want 1/%h/000000f0/9/00000400",
                     i, ex_valid, ex_op1, ex_op2, ex_waddr, ex_pc, rf[1]);
         end
      end
      flush = 1'b1;
      tick();
      flush = 1'b0; if_valid = 1'b0;
      checks++;
      if (ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_flush: ex_valid got %b, want 0", ex_valid);
      end
      void'(sbq.pop_back());
      ex_ready = 1'b1;
      // Flush beats a normal load.
      if_valid = 1'b1; flush = 1'b1;
      tick();
      idle();
      checks++;
      if (ex_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_over_load: ex_valid got %b, want 0", ex_valid);
      end
   endtask

   task automatic test_back_to_back();
      int          sent = 0;
      logic [1:0]  sel;
      logic [4:0]  rs, rt;
      logic [15:0] imm;
      logic [5:0]  op;
      logic [3:0]  aop;
      sel = 2'($urandom_range(0, 2)); rs = 5'($urandom); rt = 5'($urandom); imm = 16'($urandom);
      for (int cyc = 0; cyc < 300 && sent < 24; cyc++) begin
         op  = (sel == 2'd0) ? OP_ORI  : (sel == 2'd1) ? OP_ANDI  : OP_XORI;
         aop = (sel == 2'd0) ? ALUOP_OR : (sel == 2'd1) ? ALUOP_AND : ALUOP_XOR;
         ex_ready = ($urandom_range(0, 3) != 0);
         if_valid = 1'b1; if_instr = enc_i(op, rs, rt, imm); if_pc = 32'h1000 + 32'(sent * 4);
         #1;
         if (id_ready) begin
            sbq.push_back(mk(aop, TYPE_I, rv(rs), {16'h0, imm}, rt, 1'b1, 1'b0, 1'b0,
                             32'h1000 + 32'(sent * 4)));
            sent++;
            sel = 2'($urandom_range(0, 2)); rs = 5'($urandom); rt = 5'($urandom); imm = 16'($urandom);
         end
         tick();
      end
      idle();
      checks++;
      if (sent != 24) begin
         errors++;
         $display("FAIL b2b_timeout: sent %0d, want 24", sent);
      end
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      issue(enc_i(OP_ORI, 5'd3, 5'd4, 16'h0F0F), 32'h600,
            mk(ALUOP_OR, TYPE_I, rf[3], 32'h0F0F, 5'd4, 1'b1, 1'b0, 1'b0, 32'h600));
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (ex_valid !== 1'b0 || stall_cnt !== 16'd0 || ex_aluop !== ALUOP_OR || ex_reg_wr !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: got valid=%b stall=%0d aluop=%h wr=%b, want 0/0/%h/0",
                  ex_valid, stall_cnt, ex_aluop, ex_reg_wr, ALUOP_OR);
      end
      sbq.delete();
      exp_stall = 0;
      #4;
      rst = 1'b0;
      issue(enc_i(OP_ANDI, 5'd5, 5'd6, 16'h00FF), 32'h700,
            mk(ALUOP_AND, TYPE_I, rf[5], 32'h00FF, 5'd6, 1'b1, 1'b0, 1'b0, 32'h700));
      checks++;
      if (ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_first_accept: ex_valid got %b, want 1", ex_valid);
      end
      tick(); tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'hDEAD_BEEF;
      test_reset();
      test_ori();
      test_forwarding();
      test_load_use();
      test_movnz();
      test_shift_hilo();
      test_hold_flush();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d entries never emerged, want 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Next-generation instruction-decode stage for the MIPS32 pipeline: combinational opcode/funct decode plus operand forwarding, feeding a registered ID/EX pipeline register with valid/ready handshake.
- Adds load-use interlock, flush, forwarding-aware MOVN/MOVZ resolution and a stall-cycle counter.
- Sits between the IF/ID register and the execute stage; reads the register file directly.

Parameters:
- DATA_W, 32, datapath and register width.
- RADDR_W, 5, register-file address width (2**RADDR_W registers; register 0 is hardwired zero).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  DATA_W  PC of if_instr
- id_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  kill the instruction in ID and the ID/EX register contents
- rf_raddr1, rf_raddr2  out  RADDR_W  register-file read addresses (combinational)
- rf_rdata1, rf_rdata2  in  DATA_W  register-file read data
- ex_fwd_wr, ex_fwd_load  in  1 each  EX-stage instruction writes a register / is a load
- ex_fwd_waddr  in  RADDR_W
- ex_fwd_wdata  in  DATA_W
- mem_fwd_wr  in  1
- mem_fwd_waddr  in  RADDR_W
- mem_fwd_wdata  in  DATA_W
- ex_ready  in  1  execute stage accepts ID/EX contents
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_aluop  out  4
- ex_instr_type  out  2
- ex_op1, ex_op2  out  DATA_W  resolved operands (op2 = ext_imm for I-type)
- ex_waddr  out  RADDR_W
- ex_reg_wr, ex_mem_wr, ex_to_hi, ex_to_lo  out  1 each
- ex_pc  out  DATA_W
- stall_cnt  out  CNT_W  count of load-use stall cycles since reset

Behaviour:
- Reset (asynchronous): ex_valid=0, all ex_* outputs=0, ex_aluop=OR code, ex_instr_type=I, stall_cnt=0.
- Decode set: ORI, ANDI, XORI, LUI; SPECIAL AND, OR, XOR, NOR, SLL, SRL, SRA, SLLV, SRLV, SRAV, MOVN, MOVZ, MFHI, MFLO, MTHI, MTLO.
  - Zero-extended immediates; LUI places imm in bits [31:16].
  - Shift-by-sa uses rt as source and sa as ext_imm.
  - Variable shifts use rt as op1 and rs as op2.
  - Unknown opcode or funct decodes to a NOP (all write enables 0).
- Forwarding, per operand: a source address equal to 0 yields 0. Otherwise priority is EX match (ex_fwd_wr and ex_fwd_waddr equal) > MEM match > rf_rdata.
- MOVN/MOVZ: the condition uses the forwarded rt value. A false condition forces reg_wr=0 and waddr=0.
- Load-use hazard: ex_fwd_load & ex_fwd_wr & ex_fwd_waddr!=0 & ex_fwd_waddr equals any used source address. When it holds:
  - id_ready=0;
  - a bubble (ex_valid=0) is loaded if the ID/EX register advances;
  - stall_cnt increments by 1 per hazard cycle and saturates at all-ones.
- Otherwise id_ready = ex_ready | ~ex_valid.
- ID/EX update:
  - Loads the decoded instruction when if_valid & id_ready & ~flush.
  - Loads a bubble when (~if_valid | hazard) and the register advances.
  - Holds all contents when ex_valid & ~ex_ready.
- flush: next edge sets ex_valid=0 regardless of ex_ready. Flush has priority over hazard and over load. stall_cnt does not increment on a flush cycle.
- Latency: 1 cycle from acceptance to ex_valid.
- Throughput: 1 instruction per cycle with no hazard or backpressure.
- Reset asserted mid-stream: immediate clear; the first accept is possible on the first edge after rst deasserts.

Decomposition:
- Shared package/header (existing definitions file): opcode, funct and field-range constants; aluop_* and type_* codes; new constant NOP_ALUOP.
- One sub-module: id_fwd_mux, the per-operand forwarding priority mux, instantiated twice.

Test Plan:
- ORI $2,$1,0xFFFF with rf_rdata1=0x12340000, no hazards → next cycle ex_valid=1, ex_op1=0x12340000, ex_op2=0x0000FFFF, ex_waddr=2, ex_reg_wr=1.
- OR $3,$1,$2 with EX writing $1=0xA and MEM writing $1=0xB and $2=0xC → ex_op1=0xA (EX wins), ex_op2=0xC.
- EX load to $4, ID is AND $5,$4,$0 → id_ready=0 for 1 cycle, bubble (ex_valid=0), stall_cnt=1; then AND issues with the MEM-forwarded value.
- MOVZ $6,$7,$8 with $8 forwarded from EX as 0 → ex_reg_wr=1, waddr=6. Repeat with value 5 → reg_wr=0, waddr=0.
- ex_ready=0 for 3 cycles with valid ID/EX → all ex_* outputs hold and id_ready=0. Assert flush during the hold → ex_valid=0 next edge.
- Assert rst between edges with ex_valid=1 → ex_valid=0 and stall_cnt=0 immediately, without a clock edge.
